// File: rtl/ws2811_decoder_if.sv
// Byte output handshake of the WS2811 decoder.
//   out_data  : decoded byte
//   out_valid : out_data holds an unconsumed byte
//   out_ready : consumer accepts out_data on a clk edge when out_valid=1
// master = decoder side, slave = consumer side.
interface ws2811_decoder_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ws2811_decoder.sv
// WS2811 one-wire receiver: classifies each high pulse on din by width as a
// 0 or 1 bit, assembles bytes, presents them on a valid/ready port and marks
// frame boundaries on a T_RESET-long low gap.
// Ports:
//   clk, rst_n  : 60 MHz clock, asynchronous active-low reset
//   din         : asynchronous serial input (2-flop synchronized)
//   out_if      : byte output handshake (out_data/out_valid/out_ready)
//   frame_end   : 1-cycle pulse at a frame boundary
//   frame_len   : byte count of the last completed frame
//   bit_err     : 1-cycle pulse on a pulse-width violation
//   frame_err   : 1-cycle pulse when a frame ends with a partial byte
//   overrun     : 1-cycle pulse when an unconsumed byte is overwritten
module ws2811_decoder #(
  parameter int unsigned T_MIN      = 8,
  parameter int unsigned T_THRESH   = 38,
  parameter int unsigned T_MAX_HIGH = 75,
  parameter int unsigned T_RESET    = 3000,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned LSB_FIRST  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din,
  ws2811_decoder_if.master        out_if,
  output logic                    frame_end,
  output logic [15:0]             frame_len,
  output logic                    bit_err,
  output logic                    frame_err,
  output logic                    overrun
);

  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(T_MIN);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] MAXH_C   = CNT_W'(T_MAX_HIGH);
  localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(T_RESET);

  typedef enum logic [1:0] {ARM, IDLE, LOW, HIGH} state_t;

  state_t           state, state_next;
  logic             sync1, sync2, sync3;
  logic             rise, fall;
  logic [CNT_W-1:0] hcnt, lcnt, lcnt_inc;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg, sh_next;
  logic [15:0]      byte_cnt;
  logic             bit_val;
  logic             go_high, take_bit, err, end_frame, byte_done;

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_comb begin
    state_next = state;
    go_high    = 1'b0;
    take_bit   = 1'b0;
    err        = 1'b0;
    end_frame  = 1'b0;
    lcnt_inc   = (lcnt == '1) ? lcnt : lcnt + CNT_W'(1);
    bit_val    = (hcnt >= THRESH_C);
    if (LSB_FIRST != 0) sh_next = {bit_val, shreg[7:1]};
    else                sh_next = {shreg[6:0], bit_val};

    case (state)
      ARM: begin
        if (!sync2 && lcnt_inc == RESET_C) state_next = IDLE;
      end
      IDLE: begin
        if (rise) begin
          go_high    = 1'b1;
          state_next = HIGH;
        end
      end
      LOW: begin
        if (rise) begin
          go_high    = 1'b1;
          state_next = HIGH;
        end else if (lcnt_inc == RESET_C) begin
          end_frame  = 1'b1;
          state_next = IDLE;
        end
      end
      HIGH: begin
        if (fall) begin
          if (hcnt < MIN_C) begin
            err        = 1'b1;
            state_next = ARM;
          end else begin
            take_bit   = 1'b1;
            state_next = LOW;
          end
        end else if (hcnt >= MAXH_C) begin
          // hcnt becomes T_MAX_HIGH+1 on this edge with the line still high
          err        = 1'b1;
          state_next = ARM;
        end
      end
      default: state_next = ARM;
    endcase

    byte_done = take_bit && (bit_cnt == 3'd7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ARM;
      hcnt             <= '0;
      lcnt             <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      byte_cnt         <= '0;
      out_if.out_data  <= '0;
      out_if.out_valid <= 1'b0;
      frame_end        <= 1'b0;
      frame_len        <= '0;
      bit_err          <= 1'b0;
      frame_err        <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state     <= state_next;
      frame_end <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      bit_err   <= err;

      if (go_high)               hcnt <= CNT_W'(1);
      else if (state == HIGH)    hcnt <= hcnt + CNT_W'(1);

      if (err || take_bit)       lcnt <= '0;
      else if (state == ARM)     lcnt <= sync2 ? '0 : lcnt_inc;
      else if (state == LOW)     lcnt <= lcnt_inc;

      if (take_bit) begin
        shreg   <= sh_next;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (byte_done) begin
        out_if.out_data  <= sh_next;
        out_if.out_valid <= 1'b1;
        overrun          <= out_if.out_valid && !out_if.out_ready;
        byte_cnt         <= (byte_cnt == '1) ? byte_cnt : byte_cnt + 16'd1;
      end else if (out_if.out_valid && out_if.out_ready) begin
        out_if.out_valid <= 1'b0;
      end

      if (err) begin
        shreg    <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end

      if (end_frame) begin
        frame_end <= 1'b1;
        frame_len <= byte_cnt;
        frame_err <= (bit_cnt != 3'd0);
        shreg     <= '0;
        bit_cnt   <= '0;
        byte_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ws2811_decoder.sv
`timescale 1ns/1ps
module tb_ws2811_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        frame_end, bit_err, frame_err, overrun;
  logic [15:0] frame_len;

  ws2811_decoder_if bus();

  ws2811_decoder #(
    .T_MIN(8), .T_THRESH(38), .T_MAX_HIGH(75), .T_RESET(3000),
    .CNT_W(12), .LSB_FIRST(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .out_if(bus.master),
    .frame_end(frame_end), .frame_len(frame_len), .bit_err(bit_err),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #8 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // event counters observed away from the active edge
  int n_fe = 0, n_be = 0, n_fre = 0, n_ov = 0, n_vcyc = 0, n_acc = 0;
  logic [7:0] last_acc = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_end) n_fe++;
      if (bit_err)   n_be++;
      if (frame_err) n_fre++;
      if (overrun)   n_ov++;
      if (bus.out_valid) n_vcyc++;
      if (bus.out_valid && bus.out_ready) begin
        n_acc++;
        last_acc = bus.out_data;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int h, input int l);
    din = 1'b1;
    tick(h);
    din = 1'b0;
    tick(l);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(56, 19);
    else   pulse(19, 56);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic test_reset;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #20;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", bus.out_data); end
    checks++; if (frame_len !== 16'h0000) begin errors++; $display("FAIL rst_len: got %h expected 0000", frame_len); end
    checks++; if ({frame_end, bit_err, frame_err, overrun} !== 4'b0000) begin errors++; $display("FAIL rst_pulses: got %b expected 0000", {frame_end, bit_err, frame_err, overrun}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(3000);
  endtask

  task automatic test_basic;
    int fe0, be0, fre0, ov0, v0, a0;
    logic [7:0] v;
    v = 8'hA5;
    fe0 = n_fe; be0 = n_be; fre0 = n_fre; ov0 = n_ov; v0 = n_vcyc; a0 = n_acc;
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    din = 1'b1;
    tick(56);
    din = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat2_valid: got %b expected 0", bus.out_valid); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat3_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", bus.out_data); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed: got %b expected 0", bus.out_valid); end
    @(posedge clk); #1;
    tick(3100);
    checks++; if (n_vcyc - v0 !== 1) begin errors++; $display("FAIL basic_vcycles: got %0d expected 1", n_vcyc - v0); end
    checks++; if (n_fe - fe0 !== 1) begin errors++; $display("FAIL basic_frame_end: got %0d expected 1", n_fe - fe0); end
    checks++; if (frame_len !== 16'd1) begin errors++; $display("FAIL basic_len: got %0d expected 1", frame_len); end
    checks++; if ((n_be - be0) + (n_fre - fre0) + (n_ov - ov0) !== 0) begin errors++; $display("FAIL basic_errs: got %0d expected 0", (n_be - be0) + (n_fre - fre0) + (n_ov - ov0)); end
    checks++; if (n_acc - a0 !== 1) begin errors++; $display("FAIL basic_acc: got %0d expected 1", n_acc - a0); end
  endtask

  task automatic test_threshold;
    int fe0, be0, a0;
    int widths [8] = '{37, 38, 8, 38, 37, 38, 38, 38};
    fe0 = n_fe; be0 = n_be; a0 = n_acc;
    for (int i = 0; i < 8; i++) pulse(widths[i], 40);
    tick(10);
    checks++; if (last_acc !== 8'hEA) begin errors++; $display("FAIL thresh_data: got %h expected ea", last_acc); end
    checks++; if (n_acc - a0 !== 1) begin errors++; $display("FAIL thresh_acc: got %0d expected 1", n_acc - a0); end
    checks++; if (n_be - be0 !== 0) begin errors++; $display("FAIL thresh_noerr: got %0d expected 0", n_be - be0); end
    tick(3100);
    checks++; if (n_fe - fe0 !== 1) begin errors++; $display("FAIL thresh_fe: got %0d expected 1", n_fe - fe0); end
    pulse(7, 60);
    checks++; if (n_be - be0 !== 1) begin errors++; $display("FAIL short_pulse_err: got %0d expected 1", n_be - be0); end
    tick(3010);
    checks++; if (n_fe - fe0 !== 1) begin errors++; $display("FAIL arm_no_fe: got %0d expected 1", n_fe - fe0); end
    checks++; if (n_acc - a0 !== 1) begin errors++; $display("FAIL short_no_acc: got %0d expected 1", n_acc - a0); end
  endtask

  task automatic test_overrun;
    int ov0, fe0;
    ov0 = n_ov; fe0 = n_fe;
    bus.out_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    tick(5);
    checks++; if (n_ov - ov0 !== 1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", n_ov - ov0); end
    checks++; if (bus.out_data !== 8'h02) begin errors++; $display("FAIL ovr_data: got %h expected 02", bus.out_data); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drop: got %b expected 0", bus.out_valid); end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    tick(3100);
    checks++; if (n_fe - fe0 !== 1) begin errors++; $display("FAIL ovr_fe: got %0d expected 1", n_fe - fe0); end
    checks++; if (frame_len !== 16'd2) begin errors++; $display("FAIL ovr_len: got %0d expected 2", frame_len); end
  endtask

  task automatic test_max_high;
    int be0, fe0, a0;
    be0 = n_be; fe0 = n_fe; a0 = n_acc;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    pulse(100, 56);
    checks++; if (n_be - be0 !== 1) begin errors++; $display("FAIL maxh_err: got %0d expected 1", n_be - be0); end
    send_byte(8'h55);
    tick(3010);
    checks++; if (n_acc - a0 !== 0) begin errors++; $display("FAIL maxh_ignored: got %0d expected 0", n_acc - a0); end
    checks++; if (n_fe - fe0 !== 0) begin errors++; $display("FAIL maxh_no_fe: got %0d expected 0", n_fe - fe0); end
    send_byte(8'h3C);
    tick(3100);
    checks++; if (last_acc !== 8'h3C) begin errors++; $display("FAIL maxh_data: got %h expected 3c", last_acc); end
    checks++; if (n_fe - fe0 !== 1) begin errors++; $display("FAIL maxh_fe: got %0d expected 1", n_fe - fe0); end
    checks++; if (frame_len !== 16'd1) begin errors++; $display("FAIL maxh_len: got %0d expected 1", frame_len); end
  endtask

  task automatic test_partial;
    int fe0, fre0, be0;
    fe0 = n_fe; fre0 = n_fre; be0 = n_be;
    send_byte(8'h5A);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    tick(3100);
    checks++; if (n_fe - fe0 !== 1) begin errors++; $display("FAIL part_fe: got %0d expected 1", n_fe - fe0); end
    checks++; if (n_fre - fre0 !== 1) begin errors++; $display("FAIL part_frame_err: got %0d expected 1", n_fre - fre0); end
    checks++; if (frame_len !== 16'd1) begin errors++; $display("FAIL part_len: got %0d expected 1", frame_len); end
    checks++; if (last_acc !== 8'h5A) begin errors++; $display("FAIL part_data: got %h expected 5a", last_acc); end
    checks++; if (n_be - be0 !== 0) begin errors++; $display("FAIL part_bit_err: got %0d expected 0", n_be - be0); end
  endtask

  task automatic test_reset_midframe;
    int a0, v0, fe0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    din = 1'b1;
    tick(30);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL mrst_data: got %h expected 00", bus.out_data); end
    checks++; if (frame_len !== 16'h0000) begin errors++; $display("FAIL mrst_len: got %h expected 0000", frame_len); end
    checks++; if ({bus.out_valid, frame_end, bit_err, frame_err, overrun} !== 5'b00000) begin errors++; $display("FAIL mrst_flags: got %b expected 00000", {bus.out_valid, frame_end, bit_err, frame_err, overrun}); end
    din = 1'b0;
    tick(2);
    rst_n = 1'b1;
    a0 = n_acc; v0 = n_vcyc; fe0 = n_fe;
    send_byte(8'h00);
    send_byte(8'h0F);
    checks++; if (n_vcyc - v0 !== 0) begin errors++; $display("FAIL mrst_armed: got %0d expected 0", n_vcyc - v0); end
    tick(3010);
    checks++; if (n_fe - fe0 !== 0) begin errors++; $display("FAIL mrst_no_fe: got %0d expected 0", n_fe - fe0); end
    send_byte(8'hFF);
    tick(3100);
    checks++; if (last_acc !== 8'hFF) begin errors++; $display("FAIL mrst_data_ff: got %h expected ff", last_acc); end
    checks++; if (n_acc - a0 !== 1) begin errors++; $display("FAIL mrst_acc: got %0d expected 1", n_acc - a0); end
    checks++; if (frame_len !== 16'd1) begin errors++; $display("FAIL mrst_len_after: got %0d expected 1", frame_len); end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    test_reset;
    test_basic;
    test_threshold;
    test_overrun;
    test_max_high;
    test_partial;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
